// File: rtl/mem_port_scheduler.sv
// Shared main-memory port scheduler: buffers write-through stores, arbitrates I/D block fills,
// issues per-word block reads and steers returning words to the owning cache.
module mem_port_scheduler #(
  parameter int MEM_LAT   = 4,
  parameter int WB_DEPTH  = 4,
  parameter int BLK_WORDS = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_fill_req,
  input  logic [15:0]                  i_fill_addr,
  input  logic                         d_fill_req,
  input  logic [15:0]                  d_fill_addr,
  input  logic                         d_wr_req,
  input  logic [15:0]                  d_wr_addr,
  input  logic [15:0]                  d_wr_data,
  output logic                         wb_full,
  output logic                         wb_empty,
  output logic                         i_busy,
  output logic                         d_busy,
  output logic                         i_fill_valid,
  output logic                         d_fill_valid,
  output logic [15:0]                  fill_data,
  output logic [$clog2(BLK_WORDS)-1:0] fill_word,
  output logic                         i_fill_done,
  output logic                         d_fill_done,
  output logic                         mem_enable,
  output logic                         mem_wr,
  output logic [15:0]                  mem_addr,
  output logic [15:0]                  mem_wdata,
  input  logic [15:0]                  mem_data_in,
  input  logic                         mem_data_valid
);

  localparam int              WW          = $clog2(BLK_WORDS);
  localparam int              PW          = $clog2(WB_DEPTH);
  localparam logic [15:0]     BLK_MASK    = ~16'(2 * BLK_WORDS - 1);
  localparam logic [WW-1:0]   LAST_WORD   = WW'(BLK_WORDS - 1);
  localparam logic [PW:0]     WB_FULL_CNT = (PW + 1)'(WB_DEPTH);

  if (MEM_LAT < 1 || WB_DEPTH < 2 || (WB_DEPTH & (WB_DEPTH - 1)) != 0 ||
      (BLK_WORDS & (BLK_WORDS - 1)) != 0) begin : g_param_check
    $error("mem_port_scheduler: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, WRITE, FILL_ISSUE, FILL_WAIT} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_e;

  state_e         state_q, state_d;
  owner_e         owner_q, owner_d;
  logic [15:0]    base_q, base_d;
  logic [WW-1:0]  issue_cnt_q, issue_cnt_d;
  logic [WW-1:0]  ret_cnt_q, ret_cnt_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]    wb_cnt_q, wb_cnt_d;
  logic           mem_enable_q, mem_enable_d, mem_wr_q, mem_wr_d;
  logic [15:0]    mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [15:0]    wb_addr_mem [WB_DEPTH];
  logic [15:0]    wb_data_mem [WB_DEPTH];
  logic           enq, deq, ret_fire, ret_last;

  assign wb_empty = (wb_cnt_q == '0);
  // A full buffer refuses a store even when the same edge retires the head entry.
  assign wb_full  = (wb_cnt_q == WB_FULL_CNT);
  assign enq      = d_wr_req && !wb_full;
  assign ret_fire = mem_data_valid && (owner_q != OWN_NONE);
  assign ret_last = ret_fire && (ret_cnt_q == LAST_WORD);

  // NOTE: every signal written here gets a default first, so no path can leave it unassigned
  // and infer a latch.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    mem_enable_d = 1'b0;
    mem_wr_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    deq          = 1'b0;

    case (state_q)
      IDLE: begin
        // Stores drain ahead of a D fill so the fill never reads stale data.
        if (d_fill_req && !wb_empty) begin
          deq = 1'b1;
        end else if (d_fill_req) begin
          owner_d = OWN_D;
          base_d  = d_fill_addr & BLK_MASK;
        end else if (i_fill_req) begin
          owner_d = OWN_I;
          base_d  = i_fill_addr & BLK_MASK;
        end else if (!wb_empty) begin
          deq = 1'b1;
        end
        if (deq) begin
          state_d      = WRITE;
          mem_enable_d = 1'b1;
          mem_wr_d     = 1'b1;
          mem_addr_d   = wb_addr_mem[rd_ptr_q];
          mem_wdata_d  = wb_data_mem[rd_ptr_q];
        end else if (d_fill_req || i_fill_req) begin
          state_d      = FILL_ISSUE;
          issue_cnt_d  = '0;
          mem_enable_d = 1'b1;
          mem_addr_d   = base_d;
        end
      end
      WRITE: state_d = IDLE;
      FILL_ISSUE: begin
        if (issue_cnt_q == LAST_WORD) begin
          state_d     = FILL_WAIT;
          issue_cnt_d = '0;
        end else begin
          issue_cnt_d  = issue_cnt_q + WW'(1);
          mem_enable_d = 1'b1;
          mem_addr_d   = base_q | 16'({issue_cnt_d, 1'b0});
        end
      end
      FILL_WAIT: state_d = FILL_WAIT;
      default:   state_d = IDLE;
    endcase

    // Returns may overlap the issue phase; the last one releases the port.
    if (ret_fire) begin
      ret_cnt_d = ret_cnt_q + WW'(1);
      if (ret_last) begin
        owner_d = OWN_NONE;
        state_d = IDLE;
      end
    end

    wr_ptr_d = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = deq ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({enq, deq})
      2'b10:   wb_cnt_d = wb_cnt_q + (PW + 1)'(1);
      2'b01:   wb_cnt_d = wb_cnt_q - (PW + 1)'(1);
      default: wb_cnt_d = wb_cnt_q;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_NONE;
      base_q       <= '0;
      issue_cnt_q  <= '0;
      ret_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      wb_cnt_q     <= '0;
      mem_enable_q <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      base_q       <= base_d;
      issue_cnt_q  <= issue_cnt_d;
      ret_cnt_q    <= ret_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      wb_cnt_q     <= wb_cnt_d;
      mem_enable_q <= mem_enable_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // NOTE: buffer storage has no reset; an entry is only read after the count says it was written.
  always_ff @(posedge clk) begin
    if (enq) begin
      wb_addr_mem[wr_ptr_q] <= d_wr_addr;
      wb_data_mem[wr_ptr_q] <= d_wr_data;
    end
  end

  assign mem_enable   = mem_enable_q;
  assign mem_wr       = mem_wr_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign i_busy       = i_fill_req || (owner_q == OWN_I);
  assign d_busy       = d_fill_req || (owner_q == OWN_D);
  assign i_fill_valid = mem_data_valid && (owner_q == OWN_I);
  assign d_fill_valid = mem_data_valid && (owner_q == OWN_D);
  assign i_fill_done  = i_fill_valid && ret_last;
  assign d_fill_done  = d_fill_valid && ret_last;
  assign fill_data    = ret_fire ? mem_data_in : '0;
  assign fill_word    = ret_cnt_q;

endmodule
